// File: rtl/arbitro_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and a
// compile-time ceiling-log2 used to size the pointer and the watchdog.
package arbitro_pkg;

    typedef enum logic [1:0] {
        LIVRE    = 2'd0,
        INICIA   = 2'd1,
        ESPERA   = 2'd2,
        RESPONDE = 2'd3
    } estado_t;

    // Returns at least 1 so a single-value range still gets a real bit.
    function automatic int clog2(input int valor);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) begin
                w = i + 1;
            end
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_seletor.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module rr_seletor
    import arbitro_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] sel,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int          j;
    logic [IW-1:0] jj;

    // Walk from the farthest candidate down so the last hit is the nearest one.
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = IW'(j);
            if (req[jj]) begin
                any = 1'b1;
                idx = jj;
            end
        end
        if (any) begin
            sel = N_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/arbitro_multiplicador.sv
// Shares one sequential multiplier between N_REQ requesters with round-robin
// arbitration, a one-cycle result pulse and a watchdog for hung jobs.
//
//  state    | meaning
//  LIVRE    | idle, arbitrating when the multiplier reports idle
//  INICIA   | operands latched, St pulse to the multiplier
//  ESPERA   | waiting for Done, watchdog running
//  RESPONDE | result (or timeout) pulsed to the owner, pointer advanced
module arbitro_multiplicador
    import arbitro_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   op_a,
    input  logic [N_REQ*WIDTH-1:0]   op_b,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         res_valid,
    output logic                     res_err,
    output logic [2*WIDTH-1:0]       resultado,
    output logic                     mul_St,
    output logic [WIDTH-1:0]         mul_A,
    output logic [WIDTH-1:0]         mul_B,
    input  logic                     mul_Idle,
    input  logic                     mul_Done,
    input  logic [2*WIDTH-1:0]       mul_Produto
);

    localparam int IW = clog2(N_REQ);
    localparam int WW = clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LIM  = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] ULTIMO  = IW'(N_REQ - 1);

    estado_t           estado;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     dono;
    logic [WW-1:0]     watchdog;

    logic [N_REQ-1:0]  sel;
    logic [IW-1:0]     idx;
    logic              any;

    rr_seletor #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_seletor (
        .req (req),
        .ptr (rr_ptr),
        .sel (sel),
        .idx (idx),
        .any (any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado    <= LIVRE;
            rr_ptr    <= '0;
            dono      <= '0;
            watchdog  <= '0;
            grant     <= '0;
            res_valid <= '0;
            res_err   <= 1'b0;
            resultado <= '0;
            mul_St    <= 1'b0;
            mul_A     <= '0;
            mul_B     <= '0;
        end else begin
            mul_St    <= 1'b0;
            res_valid <= '0;
            res_err   <= 1'b0;
            case (estado)
                LIVRE: begin
                    if (any && mul_Idle) begin
                        mul_A  <= op_a[int'(idx)*WIDTH +: WIDTH];
                        mul_B  <= op_b[int'(idx)*WIDTH +: WIDTH];
                        grant  <= sel;
                        dono   <= idx;
                        mul_St <= 1'b1;
                        estado <= INICIA;
                    end
                end
                INICIA: begin
                    watchdog <= '0;
                    estado   <= ESPERA;
                end
                ESPERA: begin
                    watchdog <= watchdog + 1'b1;
                    // Done takes priority over an expiring watchdog.
                    if (mul_Done) begin
                        resultado <= mul_Produto;
                        res_valid <= N_REQ'(1) << dono;
                        estado    <= RESPONDE;
                    end else if (watchdog == WD_LIM) begin
                        resultado <= '0;
                        res_err   <= 1'b1;
                        res_valid <= N_REQ'(1) << dono;
                        estado    <= RESPONDE;
                    end
                end
                RESPONDE: begin
                    grant  <= '0;
                    rr_ptr <= (dono == ULTIMO) ? '0 : dono + 1'b1;
                    estado <= LIVRE;
                end
                default: begin
                    estado <= LIVRE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Self-checking bench for arbitro_multiplicador with a behavioural multiplier
// and an arbitration/result model checked every cycle.
module tb_arbitro_multiplicador;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   op_a, op_b;
    logic [N-1:0]     grant, res_valid;
    logic             res_err;
    logic [2*W-1:0]   resultado;
    logic             mul_St;
    logic [W-1:0]     mul_A, mul_B;
    logic             mul_Idle, mul_Done;
    logic [2*W-1:0]   mul_Produto;

    always #5 clk = ~clk;

    arbitro_multiplicador #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .grant       (grant),
        .res_valid   (res_valid),
        .res_err     (res_err),
        .resultado   (resultado),
        .mul_St      (mul_St),
        .mul_A       (mul_A),
        .mul_B       (mul_B),
        .mul_Idle    (mul_Idle),
        .mul_Done    (mul_Done),
        .mul_Produto (mul_Produto)
    );

    // Multiplier model: Done arrives mlat cycles after the St cycle.
    int          mlat = 3;
    bit          hang = 1'b0;
    bit          idle_hold = 1'b0;
    int          mcnt;
    logic [W-1:0] pa, pb;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt <= 0;
            pa   <= '0;
            pb   <= '0;
        end else if (mul_St) begin
            mcnt <= mlat;
            pa   <= mul_A;
            pb   <= mul_B;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end

    assign mul_Done    = (mcnt == 1) && !hang;
    assign mul_Idle    = (mcnt == 0) && !idle_hold;
    assign mul_Produto = {{W{1'b0}}, pa} * {{W{1'b0}}, pb};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Model state and result log
    int           cyc = 0;
    bit           busy = 1'b0;
    int           mown = 0;
    int           mptr = 0;
    int           st_cyc = 0;
    int           st_count = 0;
    bit           e_err;
    int           e_lat;
    logic [W-1:0] ea, eb;
    logic [N-1:0]   req_prev = '0;
    logic [N*W-1:0] a_prev = '0, b_prev = '0;
    int           log_own[$];
    logic [31:0]  log_res[$];
    bit           log_err[$];

    task automatic monitor();
        logic [31:0] eprod;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 1'b0;
                mptr = 0;
            end else begin
                cyc++;
                chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
                if (mul_St) begin
                    chk("st_while_busy", 64'(busy), 64'd0);
                    mown = pick(req_prev, mptr);
                    if (mown < 0) begin
                        chk("st_without_req", 64'(mown), 64'd0);
                        mown = 0;
                    end
                    ea = a_prev[mown*W +: W];
                    eb = b_prev[mown*W +: W];
                    chk("grant_owner", 64'(grant), 64'(N'(1) << mown));
                    chk("mul_A", 64'(mul_A), 64'(ea));
                    chk("mul_B", 64'(mul_B), 64'(eb));
                    e_err  = hang || (mlat > TO);
                    e_lat  = e_err ? TO + 1 : mlat + 1;
                    busy   = 1'b1;
                    st_cyc = cyc;
                    st_count++;
                end else if (busy) begin
                    chk("grant_hold", 64'(grant), 64'(N'(1) << mown));
                end else begin
                    chk("grant_idle", 64'(grant), 64'd0);
                end
                if (res_valid != '0) begin
                    chk("res_while_busy", 64'(busy), 64'd1);
                    chk("res_valid_owner", 64'(res_valid), 64'(N'(1) << mown));
                    chk("latency", 64'(cyc - st_cyc), 64'(e_lat));
                    chk("res_err", 64'(res_err), 64'(e_err));
                    eprod = e_err ? 32'd0 : 32'(ea) * 32'(eb);
                    chk("resultado", 64'(resultado), 64'(eprod));
                    log_own.push_back(mown);
                    log_res.push_back(resultado);
                    log_err.push_back(res_err);
                    mptr = (mown + 1) % N;
                    busy = 1'b0;
                end else begin
                    chk("res_err_idle", 64'(res_err), 64'd0);
                end
            end
            req_prev = req;
            a_prev   = op_a;
            b_prev   = op_b;
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
    endtask

    task automatic run_jobs(input int n, input bit auto_drop);
        int alvo;
        alvo = log_own.size() + n;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (auto_drop) req = req & ~res_valid;
            if (log_own.size() >= alvo) break;
        end
        chk("jobs_done", 64'(log_own.size()), 64'(alvo));
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_log(input string nome, input int k, input int own, input logic [31:0] res, input bit err);
        if (k < log_own.size()) begin
            chk({nome, "_owner"}, 64'(log_own[k]), 64'(own));
            chk({nome, "_res"}, 64'(log_res[k]), 64'(res));
            chk({nome, "_err"}, 64'(log_err[k]), 64'(err));
        end else begin
            chk({nome, "_missing"}, 64'(log_own.size()), 64'(k + 1));
        end
    endtask

    initial begin
        int base;
        int n0;
        fork
            monitor();
        join_none
        rst  = 1'b0;
        req  = '0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_err", 64'(res_err), 64'd0);
        chk("rst_mul_St", 64'(mul_St), 64'd0);
        chk("rst_resultado", 64'(resultado), 64'd0);
        chk("rst_mul_A", 64'(mul_A), 64'd0);
        chk("rst_mul_B", 64'(mul_B), 64'd0);
        rst = 1'b1;

        // Single requester 0
        base = log_own.size();
        n0 = st_count;
        set_op(0, 16'd5000, 16'd6000);
        req = 4'b0001;
        run_jobs(1, 1'b1);
        chk_log("t1", base, 0, 32'd30000000, 1'b0);
        chk("t1_st_pulses", 64'(st_count - n0), 64'd1);

        // All four together from ptr=0
        reset_dut();
        base = log_own.size();
        for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 16'd10);
        req = 4'b1111;
        run_jobs(4, 1'b1);
        for (int i = 0; i < N; i++) chk_log("t2", base + i, i, 32'((i + 1) * 10), 1'b0);

        // Fairness with two held requesters from ptr=2
        reset_dut();
        set_op(1, 16'd7, 16'd9);
        req = 4'b0010;
        run_jobs(1, 1'b1);
        base = log_own.size();
        set_op(2, 16'hFFFF, 16'hFFFF);
        req = 4'b0110;
        run_jobs(4, 1'b0);
        req = '0;
        chk_log("t3a", base,     2, 32'hFFFE0001, 1'b0);
        chk_log("t3b", base + 1, 1, 32'd63,       1'b0);
        chk_log("t3c", base + 2, 2, 32'hFFFE0001, 1'b0);
        chk_log("t3d", base + 3, 1, 32'd63,       1'b0);

        // Hung multiplier, then normal service
        base = log_own.size();
        hang = 1'b1;
        set_op(3, 16'd100, 16'd200);
        req = 4'b1000;
        run_jobs(1, 1'b1);
        hang = 1'b0;
        set_op(0, 16'd5000, 16'd6000);
        req = 4'b0001;
        run_jobs(1, 1'b1);
        chk_log("t4_to", base,     3, 32'd0,        1'b1);
        chk_log("t4_ok", base + 1, 0, 32'd30000000, 1'b0);

        // Done in the same cycle the watchdog expires
        base = log_own.size();
        mlat = TO;
        set_op(2, 16'd3, 16'd4);
        req = 4'b0100;
        run_jobs(1, 1'b1);
        mlat = 3;
        chk_log("t7", base, 2, 32'd12, 1'b0);

        // Reset mid-job
        mlat = 20;
        set_op(0, 16'd3, 16'd15);
        req = 4'b0001;
        repeat (8) @(posedge clk);
        n0 = log_own.size();
        #2;
        rst = 1'b0;
        #1;
        chk("t5_grant", 64'(grant), 64'd0);
        chk("t5_res_valid", 64'(res_valid), 64'd0);
        chk("t5_mul_St", 64'(mul_St), 64'd0);
        chk("t5_resultado", 64'(resultado), 64'd0);
        chk("t5_mul_A", 64'(mul_A), 64'd0);
        mlat = 3;
        set_op(0, 16'd1, 16'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("t5_no_pulse", 64'(log_own.size()), 64'(n0));
        base = log_own.size();
        run_jobs(1, 1'b1);
        chk_log("t5", base, 0, 32'd1, 1'b0);

        // Multiplier busy holds off the grant
        base = log_own.size();
        idle_hold = 1'b1;
        set_op(0, 16'd2, 16'd3);
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t6_no_grant", 64'(grant), 64'd0);
        end
        idle_hold = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_grant", 64'(grant), 64'd1);
        run_jobs(1, 1'b1);
        chk_log("t6", base, 0, 32'd6, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
